// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipelined core: ALU encodings, the
// control-bit bundle carried between stages, and its bubble value.
package cpu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_AND  = 4'h2,
    ALU_OR   = 4'h3,
    ALU_XOR  = 4'h4,
    ALU_SLL  = 4'h5,
    ALU_SRL  = 4'h6,
    ALU_SLT  = 4'h7,
    ALU_PASS = 4'h8
  } alu_op_e;

  localparam logic [3:0] REG_ZERO = 4'h0;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       alusrc;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       halt;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_pipe_reg_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  output logic [CW-1:0] count
);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      count_q <= '0;
    else if (inc && (count_q != '1)) count_q <= count_q + 1'b1;
  end

  assign count = count_q;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: bubbles on flush/stall/halt, WB write-through
// into operands, sticky halt flag and saturating stall/flush counters.
module id_ex_pipe_reg
  import cpu_pkg::*;
#(
  parameter int DW = 16,
  parameter int RW = 4,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall_n,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [DW-1:0] id_pc,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic [3:0]    id_alu_op,
  input  logic          id_alusrc,
  input  logic          id_regwrite,
  input  logic          id_memread,
  input  logic          id_memwrite,
  input  logic          id_memtoreg,
  input  logic          id_halt,
  input  logic          wb_regwrite,
  input  logic [RW-1:0] wb_rd,
  input  logic [DW-1:0] wb_data,
  output logic          ex_valid,
  output logic [DW-1:0] ex_pc,
  output logic [DW-1:0] ex_rs_data,
  output logic [DW-1:0] ex_rt_data,
  output logic [DW-1:0] ex_imm,
  output logic [RW-1:0] ex_rs,
  output logic [RW-1:0] ex_rt,
  output logic [RW-1:0] ex_rd,
  output logic [3:0]    ex_alu_op,
  output logic          ex_alusrc,
  output logic          ex_regwrite,
  output logic          ex_memread,
  output logic          ex_memwrite,
  output logic          ex_memtoreg,
  output logic          ex_halt,
  output logic          halted,
  output logic [CW-1:0] stall_count,
  output logic [CW-1:0] flush_count
);

  logic          valid_q, valid_d;
  logic [DW-1:0] pc_q, pc_d, rs_data_q, rs_data_d, rt_data_q, rt_data_d, imm_q, imm_d;
  logic [RW-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  ctrl_t         ctrl_q, ctrl_d, id_ctrl;
  logic          halted_q, halted_d;
  logic          load, wt_rs, wt_rt;

  assign id_ctrl = '{alu_op: id_alu_op, alusrc: id_alusrc, regwrite: id_regwrite,
                     memread: id_memread, memwrite: id_memwrite,
                     memtoreg: id_memtoreg, halt: id_halt};

  assign load  = flush == 1'b0 && stall_n && !halted_q;
  // R0 is hardwired, so a WB "write" to it must never be forwarded.
  assign wt_rs = wb_regwrite && (wb_rd != RW'(REG_ZERO)) && (wb_rd == id_rs);
  assign wt_rt = wb_regwrite && (wb_rd != RW'(REG_ZERO)) && (wb_rd == id_rt);

  always_comb begin
    valid_d   = 1'b0;
    pc_d      = '0;
    rs_d      = '0;
    rt_d      = '0;
    rd_d      = '0;
    rs_data_d = '0;
    rt_data_d = '0;
    imm_d     = '0;
    ctrl_d    = CTRL_BUBBLE;
    halted_d  = halted_q;
    if (load) begin
      valid_d   = id_valid;
      pc_d      = id_pc;
      rs_d      = id_rs;
      rt_d      = id_rt;
      rd_d      = id_rd;
      rs_data_d = wt_rs ? wb_data : id_rs_data;
      rt_data_d = wt_rt ? wb_data : id_rt_data;
      imm_d     = id_imm;
      ctrl_d    = id_ctrl;
      halted_d  = halted_q | (id_valid & id_halt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      ctrl_q    <= CTRL_BUBBLE;
      halted_q  <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      ctrl_q    <= ctrl_d;
      halted_q  <= halted_d;
    end
  end

  // Flush outranks stall, so a coincident stall is not counted.
  sat_counter #(.CW(CW)) u_stall_cnt (
    .clk(clk), .rst_n(rst_n), .inc(!flush && !stall_n), .count(stall_count));
  sat_counter #(.CW(CW)) u_flush_cnt (
    .clk(clk), .rst_n(rst_n), .inc(flush), .count(flush_count));

  assign ex_valid    = valid_q;
  assign ex_pc       = pc_q;
  assign ex_rs       = rs_q;
  assign ex_rt       = rt_q;
  assign ex_rd       = rd_q;
  assign ex_rs_data  = rs_data_q;
  assign ex_rt_data  = rt_data_q;
  assign ex_imm      = imm_q;
  assign ex_alu_op   = ctrl_q.alu_op;
  assign ex_alusrc   = ctrl_q.alusrc;
  assign ex_regwrite = ctrl_q.regwrite;
  assign ex_memread  = ctrl_q.memread;
  assign ex_memwrite = ctrl_q.memwrite;
  assign ex_memtoreg = ctrl_q.memtoreg;
  assign ex_halt     = ctrl_q.halt;
  assign halted      = halted_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg.
module tb_id_ex_pipe_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_n, flush, id_valid;
  logic [15:0] id_pc, id_rs_data, id_rt_data, id_imm, wb_data;
  logic [3:0]  id_rs, id_rt, id_rd, id_alu_op, wb_rd;
  logic        id_alusrc, id_regwrite, id_memread, id_memwrite, id_memtoreg, id_halt;
  logic        wb_regwrite;
  logic        ex_valid;
  logic [15:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm;
  logic [3:0]  ex_rs, ex_rt, ex_rd, ex_alu_op;
  logic        ex_alusrc, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_halt;
  logic        halted;
  logic [15:0] stall_count, flush_count;

  int pass_cnt = 0;
  int total = 0;

  always #5 clk = ~clk;

  id_ex_pipe_reg dut (
    .clk(clk), .rst_n(rst_n), .stall_n(stall_n), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_alu_op(id_alu_op), .id_alusrc(id_alusrc), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
    .id_halt(id_halt), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_alu_op(ex_alu_op),
    .ex_alusrc(ex_alusrc), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg), .ex_halt(ex_halt),
    .halted(halted), .stall_count(stall_count), .flush_count(flush_count));

  task automatic clear_inputs();
    stall_n = 1'b1; flush = 1'b0; id_valid = 1'b0; id_pc = '0;
    id_rs = '0; id_rt = '0; id_rd = '0; id_rs_data = '0; id_rt_data = '0; id_imm = '0;
    id_alu_op = '0; id_alusrc = 1'b0; id_regwrite = 1'b0; id_memread = 1'b0;
    id_memwrite = 1'b0; id_memtoreg = 1'b0; id_halt = 1'b0;
    wb_regwrite = 1'b0; wb_rd = '0; wb_data = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [127:0] all_out;
    clear_inputs();
    rst_n = 1'b0;
    #2;
    all_out = {ex_valid, ex_pc, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd, ex_alu_op,
               ex_alusrc, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_halt,
               halted, stall_count, flush_count};
    total++;
    if (all_out !== '0) $display("FAIL reset_state: got %h want 0", all_out);
    else pass_cnt++;
    step();
    rst_n = 1'b1;
    // reset mid-stream
    id_valid = 1'b1; id_rd = 4'd5; id_regwrite = 1'b1; id_pc = 16'h0042;
    step();
    total++;
    if ({ex_valid, ex_rd, ex_regwrite, ex_pc} !== {1'b1, 4'd5, 1'b1, 16'h0042})
      $display("FAIL pre_reset_load: got %b/%0d/%b/%h want 1/5/1/0042",
               ex_valid, ex_rd, ex_regwrite, ex_pc);
    else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({ex_valid, ex_rd, ex_regwrite, ex_pc} !== '0)
      $display("FAIL async_reset: got %b/%0d/%b/%h want all 0",
               ex_valid, ex_rd, ex_regwrite, ex_pc);
    else pass_cnt++;
    step();
    rst_n = 1'b1;
    // first edge after release loads normally
    step();
    total++;
    if ({ex_valid, ex_rd, ex_regwrite} !== {1'b1, 4'd5, 1'b1})
      $display("FAIL post_reset_load: got %b/%0d/%b want 1/5/1", ex_valid, ex_rd, ex_regwrite);
    else pass_cnt++;
    clear_inputs();
  endtask

  task automatic test_load();
    clear_inputs();
    id_valid = 1'b1; id_rs = 4'd2; id_rt = 4'd7; id_rd = 4'd9; id_rs_data = 16'h1234;
    id_rt_data = 16'h5678; id_imm = 16'hFFF0; id_alu_op = 4'h1; id_regwrite = 1'b1;
    id_pc = 16'h0100; id_alusrc = 1'b1; id_memtoreg = 1'b1;
    step();
    total++;
    if ({ex_rs, ex_rs_data, ex_imm, ex_regwrite, ex_valid, ex_alu_op} !==
        {4'd2, 16'h1234, 16'hFFF0, 1'b1, 1'b1, 4'h1})
      $display("FAIL load_main: got rs=%0d d=%h imm=%h rw=%b v=%b op=%h",
               ex_rs, ex_rs_data, ex_imm, ex_regwrite, ex_valid, ex_alu_op);
    else pass_cnt++;
    total++;
    if ({ex_rt, ex_rd, ex_rt_data, ex_pc, ex_alusrc, ex_memtoreg, ex_memread, ex_memwrite} !==
        {4'd7, 4'd9, 16'h5678, 16'h0100, 1'b1, 1'b1, 1'b0, 1'b0})
      $display("FAIL load_rest: got rt=%0d rd=%0d d=%h pc=%h as=%b mtr=%b mr=%b mw=%b",
               ex_rt, ex_rd, ex_rt_data, ex_pc, ex_alusrc, ex_memtoreg, ex_memread, ex_memwrite);
    else pass_cnt++;
    // invalid slot: control loaded as presented
    id_valid = 1'b0; id_regwrite = 1'b0; id_rd = 4'd3; id_memwrite = 1'b1;
    step();
    total++;
    if ({ex_valid, ex_rd, ex_memwrite, ex_regwrite} !== {1'b0, 4'd3, 1'b1, 1'b0})
      $display("FAIL load_invalid: got v=%b rd=%0d mw=%b rw=%b want 0/3/1/0",
               ex_valid, ex_rd, ex_memwrite, ex_regwrite);
    else pass_cnt++;
    clear_inputs();
  endtask

  task automatic test_stall();
    do_reset();
    clear_inputs();
    id_valid = 1'b1; id_memread = 1'b1; id_rt = 4'd3; id_rs = 4'd6; id_rs_data = 16'hAAAA;
    stall_n = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      step();
      total++;
      if ({ex_valid, ex_memread, ex_rt, ex_rs, ex_rs_data, stall_count} !==
          {1'b0, 1'b0, 4'd0, 4'd0, 16'h0, 16'(i)})
        $display("FAIL stall_bubble%0d: got v=%b mr=%b rt=%0d rs=%0d d=%h sc=%0d want sc=%0d",
                 i, ex_valid, ex_memread, ex_rt, ex_rs, ex_rs_data, stall_count, i);
      else pass_cnt++;
    end
    flush = 1'b1;
    step();
    total++;
    if ({ex_valid, ex_memread, stall_count, flush_count} !== {1'b0, 1'b0, 16'd2, 16'd1})
      $display("FAIL stall_and_flush: got v=%b mr=%b sc=%0d fc=%0d want 0/0/2/1",
               ex_valid, ex_memread, stall_count, flush_count);
    else pass_cnt++;
    stall_n = 1'b1;
    step();
    total++;
    if ({ex_valid, stall_count, flush_count} !== {1'b0, 16'd2, 16'd2})
      $display("FAIL flush_only: got v=%b sc=%0d fc=%0d want 0/2/2",
               ex_valid, stall_count, flush_count);
    else pass_cnt++;
    flush = 1'b0;
    step();
    total++;
    if ({ex_valid, ex_memread, ex_rt} !== {1'b1, 1'b1, 4'd3})
      $display("FAIL resume_after_stall: got v=%b mr=%b rt=%0d want 1/1/3",
               ex_valid, ex_memread, ex_rt);
    else pass_cnt++;
    clear_inputs();
  endtask

  task automatic test_writethrough();
    clear_inputs();
    id_valid = 1'b1; id_rs = 4'd4; id_rt = 4'd4; id_rs_data = 16'h0001; id_rt_data = 16'h0002;
    wb_regwrite = 1'b1; wb_rd = 4'd4; wb_data = 16'hBEEF;
    step();
    total++;
    if ({ex_rs_data, ex_rt_data} !== {16'hBEEF, 16'hBEEF})
      $display("FAIL wt_both: got %h/%h want BEEF/BEEF", ex_rs_data, ex_rt_data);
    else pass_cnt++;
    id_rs = 4'd0; id_rt = 4'd0; wb_rd = 4'd0;
    step();
    total++;
    if ({ex_rs_data, ex_rt_data} !== {16'h0001, 16'h0002})
      $display("FAIL wt_r0: got %h/%h want 0001/0002", ex_rs_data, ex_rt_data);
    else pass_cnt++;
    id_rs = 4'd4; id_rt = 4'd5; wb_rd = 4'd5;
    step();
    total++;
    if ({ex_rs_data, ex_rt_data} !== {16'h0001, 16'hBEEF})
      $display("FAIL wt_rt_only: got %h/%h want 0001/BEEF", ex_rs_data, ex_rt_data);
    else pass_cnt++;
    wb_regwrite = 1'b0; wb_rd = 4'd4;
    step();
    total++;
    if ({ex_rs_data, ex_rt_data} !== {16'h0001, 16'h0002})
      $display("FAIL wt_no_we: got %h/%h want 0001/0002", ex_rs_data, ex_rt_data);
    else pass_cnt++;
    wb_regwrite = 1'b1; wb_rd = 4'd4; stall_n = 1'b0;
    step();
    total++;
    if ({ex_valid, ex_rs_data} !== {1'b0, 16'h0000})
      $display("FAIL wt_on_stall: got v=%b d=%h want 0/0000", ex_valid, ex_rs_data);
    else pass_cnt++;
    clear_inputs();
  endtask

  task automatic test_halt();
    do_reset();
    clear_inputs();
    id_valid = 1'b1; id_halt = 1'b1; flush = 1'b1;
    step();
    total++;
    if ({halted, ex_halt, ex_valid, flush_count} !== {1'b0, 1'b0, 1'b0, 16'd1})
      $display("FAIL halt_flushed: got h=%b eh=%b v=%b fc=%0d want 0/0/0/1",
               halted, ex_halt, ex_valid, flush_count);
    else pass_cnt++;
    flush = 1'b0; id_valid = 1'b0;
    step();
    total++;
    if ({halted, ex_halt} !== {1'b0, 1'b1})
      $display("FAIL halt_invalid: got h=%b eh=%b want 0/1", halted, ex_halt);
    else pass_cnt++;
    id_valid = 1'b1;
    step();
    total++;
    if ({halted, ex_halt, ex_valid} !== {1'b1, 1'b1, 1'b1})
      $display("FAIL halt_set: got h=%b eh=%b v=%b want 1/1/1", halted, ex_halt, ex_valid);
    else pass_cnt++;
    id_halt = 1'b0; id_regwrite = 1'b1; id_rd = 4'd7;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if ({halted, ex_valid, ex_regwrite, ex_rd, ex_halt} !== {1'b1, 1'b0, 1'b0, 4'd0, 1'b0})
        $display("FAIL after_halt%0d: got h=%b v=%b rw=%b rd=%0d eh=%b want 1/0/0/0/0",
                 i, halted, ex_valid, ex_regwrite, ex_rd, ex_halt);
      else pass_cnt++;
    end
    total++;
    if ({stall_count, flush_count} !== {16'd0, 16'd1})
      $display("FAIL halt_counters: got sc=%0d fc=%0d want 0/1", stall_count, flush_count);
    else pass_cnt++;
    clear_inputs();
  endtask

  task automatic test_saturation();
    do_reset();
    clear_inputs();
    stall_n = 1'b0;
    for (int i = 0; i < 65534; i++) step();
    total++;
    if (stall_count !== 16'hFFFE)
      $display("FAIL sat_near: got %h want FFFE", stall_count);
    else pass_cnt++;
    step();
    total++;
    if (stall_count !== 16'hFFFF)
      $display("FAIL sat_reach: got %h want FFFF", stall_count);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) step();
    total++;
    if ({stall_count, flush_count} !== {16'hFFFF, 16'h0000})
      $display("FAIL sat_hold: got sc=%h fc=%h want FFFF/0000", stall_count, flush_count);
    else pass_cnt++;
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_load();
    test_stall();
    test_writethrough();
    test_halt();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
